// File: rtl/latch_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : latch_write_sequencer
// Brief    : Drives LAT_I/LAT_GE/LAT_SET/LAT_RST of a gated-latch bank with
//            setup/open/hold sequencing. Define LATCH_CHECK_EN for readback.
// Revision : 1.0
// ============================================================================
module latch_write_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_cmd,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] lat_i,
  output logic             lat_ge,
  output logic             lat_set,
  output logic             lat_rst,
  input  logic [WIDTH-1:0] lat_o,
  output logic             busy,
  output logic             done,
  output logic             chk_err
);

  localparam logic [1:0] c_cmd_write = 2'b00;
  localparam logic [1:0] c_cmd_set   = 2'b01;
  localparam logic [1:0] c_cmd_clr   = 2'b10;
  localparam logic [1:0] c_cmd_nop   = 2'b11;

  localparam logic [3:0] c_setup_ld = 4'(SETUP_CYC - 1);
  localparam logic [3:0] c_open_ld  = 4'(OPEN_CYC - 1);
  localparam logic [3:0] c_hold_ld  = 4'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_OPEN  = 3'd2,
    S_HOLD  = 3'd3,
    S_FORCE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [1:0]       r_cmd, w_cmd_eff;
  logic             w_accept;
  logic [WIDTH-1:0] r_lat_i;
  logic             r_ready, r_ge, r_set, r_rst, r_done;

  assign w_accept  = in_valid & r_ready;
  assign w_cmd_eff = w_accept ? in_cmd : r_cmd;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (in_cmd)
            c_cmd_write: begin
              w_state_nxt = S_SETUP;
              w_cnt_nxt   = c_setup_ld;
            end
            c_cmd_set, c_cmd_clr: begin
              w_state_nxt = S_FORCE;
              w_cnt_nxt   = c_open_ld;
            end
            default: w_state_nxt = S_FIN;
          endcase
        end
      end
      S_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_OPEN;
          w_cnt_nxt   = c_open_ld;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_OPEN: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = c_hold_ld;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_HOLD, S_FORCE: begin
        if (r_cnt == 4'd0) w_state_nxt = S_FIN;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave a flop with no decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_cmd   <= c_cmd_nop;
      r_lat_i <= '0;
      r_ready <= 1'b0;
      r_ge    <= 1'b0;
      r_set   <= 1'b0;
      r_rst   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cmd   <= w_cmd_eff;
      if (w_accept && in_cmd == c_cmd_write) r_lat_i <= in_data;
      r_ready <= (w_state_nxt == S_IDLE);
      r_ge    <= (w_state_nxt == S_OPEN);
      r_set   <= (w_state_nxt == S_FORCE) && (w_cmd_eff == c_cmd_set);
      r_rst   <= (w_state_nxt == S_FORCE) && (w_cmd_eff == c_cmd_clr);
      r_done  <= (w_state_nxt == S_FIN);
    end
  end

  assign in_ready = r_ready;
  assign lat_i    = r_lat_i;
  assign lat_ge   = r_ge;
  assign lat_set  = r_set;
  assign lat_rst  = r_rst;
  assign done     = r_done;
  assign busy     = (r_state != S_IDLE);

`ifdef LATCH_CHECK_EN
  logic [WIDTH-1:0] w_expected;
  always_comb begin
    w_expected = r_lat_i;
    if (r_cmd == c_cmd_set) w_expected = '1;
    else if (r_cmd == c_cmd_clr) w_expected = '0;
  end
  assign chk_err = (r_state == S_FIN) && (r_cmd != c_cmd_nop) && (lat_o != w_expected);
`else
  logic w_unused_lat_o;
  assign w_unused_lat_o = ^lat_o;
  assign chk_err        = 1'b0;
`endif

  a_strobe_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({lat_ge, lat_set, lat_rst}));

endmodule
`default_nettype wire

// File: tb/tb_latch_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_latch_write_sequencer
// Brief    : Directed vector table plus hand sequences for back-to-back,
//            reset-abort and long-timing cases of latch_write_sequencer.
// Revision : 1.0
// ============================================================================
module tb_latch_write_sequencer;

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] data;
    logic       broken;
    logic [7:0] exp_li;
    int         exp_lat;
    int         exp_ge;
    int         exp_set;
    int         exp_rst;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid = 1'b0;
  logic [1:0] in_cmd   = 2'b11;
  logic [7:0] in_data  = 8'h00;
  logic       sel      = 1'b0;
  logic       broken   = 1'b0;
  logic [7:0] m_latch  = 8'h00;
  logic [7:0] lat_o_model;

  logic       a_valid, a_ready, a_ge, a_set, a_rst, a_busy, a_done, a_chk;
  logic [7:0] a_lat_i;
  logic       b_valid, b_ready, b_ge, b_set, b_rst, b_busy, b_done, b_chk;
  logic [7:0] b_lat_i;
  logic       o_ready, o_ge, o_set, o_rst, o_busy, o_done, o_chk;
  logic [7:0] o_lat_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign a_valid = in_valid & ~sel;
  assign b_valid = in_valid & sel;

  latch_write_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_cmd(in_cmd), .in_data(in_data), .lat_i(a_lat_i), .lat_ge(a_ge),
    .lat_set(a_set), .lat_rst(a_rst), .lat_o(lat_o_model), .busy(a_busy),
    .done(a_done), .chk_err(a_chk)
  );

  latch_write_sequencer #(.WIDTH(8), .SETUP_CYC(15), .OPEN_CYC(15), .HOLD_CYC(15)) dut15 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_cmd(in_cmd), .in_data(in_data), .lat_i(b_lat_i), .lat_ge(b_ge),
    .lat_set(b_set), .lat_rst(b_rst), .lat_o(lat_o_model), .busy(b_busy),
    .done(b_done), .chk_err(b_chk)
  );

  assign o_ready = sel ? b_ready : a_ready;
  assign o_ge    = sel ? b_ge    : a_ge;
  assign o_set   = sel ? b_set   : a_set;
  assign o_rst   = sel ? b_rst   : a_rst;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_chk   = sel ? b_chk   : a_chk;
  assign o_lat_i = sel ? b_lat_i : a_lat_i;

  // Behavioural latch bank; "broken" models a bank stuck at zero.
  always @(posedge clk) begin
    if (o_ge)       m_latch <= o_lat_i;
    else if (o_set) m_latch <= 8'hFF;
    else if (o_rst) m_latch <= 8'h00;
  end
  assign lat_o_model = broken ? 8'h00 : m_latch;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] cmd, input logic [7:0] data, input logic brk,
                              input logic [7:0] li, input int lat, input int ge, input int st,
                              input int rs);
    vec_t v;
    v.cmd = cmd; v.data = data; v.broken = brk; v.exp_li = li;
    v.exp_lat = lat; v.exp_ge = ge; v.exp_set = st; v.exp_rst = rs;
    return v;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge following DONE.
  task automatic run_cmd(input vec_t v, input string name);
    int   k, lat, nge, nset, nrst;
    bit   ovl, rdy_bad, chk_bad, found;
    logic chk_done, busy0;
    logic [7:0] li0;
    k = 0;
    while (!o_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check({name, "_ready_before"}, o_ready, 1);
    broken   = v.broken;
    in_valid = 1'b1; in_cmd = v.cmd; in_data = v.data;
    @(posedge clk); #1;
    in_valid = 1'b0; in_cmd = 2'b00; in_data = ~v.data;
    li0 = o_lat_i; busy0 = o_busy;
    lat = -1; nge = 0; nset = 0; nrst = 0; ovl = 0; rdy_bad = 0; chk_bad = 0;
    chk_done = 1'b0; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      nge  += int'(o_ge);
      nset += int'(o_set);
      nrst += int'(o_rst);
      if (int'(o_ge) + int'(o_set) + int'(o_rst) > 1) ovl = 1;
      if (o_ready) rdy_bad = 1;
      if (o_done) begin
        lat = i; chk_done = o_chk; found = 1;
      end else begin
        if (o_chk) chk_bad = 1;
        @(posedge clk); #1;
      end
    end
    check({name, "_lat_i_at_accept"}, li0, v.exp_li);
    check({name, "_busy_at_accept"}, busy0, 1);
    check({name, "_latency"}, lat, v.exp_lat);
    check({name, "_ge_cycles"}, nge, v.exp_ge);
    check({name, "_set_cycles"}, nset, v.exp_set);
    check({name, "_rst_cycles"}, nrst, v.exp_rst);
    check({name, "_strobe_overlap"}, ovl, 0);
    check({name, "_ready_while_busy"}, rdy_bad, 0);
    check({name, "_chk_outside_fin"}, chk_bad, 0);
`ifdef LATCH_CHECK_EN
    check({name, "_chk_err"}, chk_done, v.broken);
`else
    check({name, "_chk_err"}, chk_done, 0);
`endif
    check({name, "_lat_i_at_done"}, o_lat_i, v.exp_li);
    @(posedge clk); #1;
    broken = 1'b0;
    check({name, "_ready_after"}, o_ready, 1);
    check({name, "_done_single"}, o_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int d1, d2, acc2, dcount;
    logic rdy_prev;

    vecs[0] = mk(2'b00, 8'hA5, 1'b0, 8'hA5, 4, 2, 0, 0);
    vecs[1] = mk(2'b01, 8'h00, 1'b0, 8'hA5, 2, 0, 2, 0);
    vecs[2] = mk(2'b10, 8'hFF, 1'b0, 8'hA5, 2, 0, 0, 2);
    vecs[3] = mk(2'b11, 8'hFF, 1'b0, 8'hA5, 0, 0, 0, 0);
    vecs[4] = mk(2'b00, 8'h81, 1'b1, 8'h81, 4, 2, 0, 0);
    vecs[5] = mk(2'b00, 8'h81, 1'b0, 8'h81, 4, 2, 0, 0);
    vecs[6] = mk(2'b11, 8'h00, 1'b0, 8'h81, 0, 0, 0, 0);
    vecs[7] = mk(2'b00, 8'h00, 1'b0, 8'h00, 4, 2, 0, 0);

    // Reset state
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", a_ready, 0);
    check("rst_strobes", {a_ge, a_set, a_rst}, 0);
    check("rst_done_busy_chk", {a_done, a_busy, a_chk}, 0);
    check("rst_lat_i", a_lat_i, 0);
    check("rst_ready_b", b_ready, 0);
    #2 rst_n = 1'b1;
    #1 check("release_ready_before_edge", a_ready, 0);
    @(posedge clk); #1;
    check("release_ready_after_edge", a_ready, 1);

    foreach (vecs[i]) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back writes with IN_VALID held high
    in_valid = 1'b1; in_cmd = 2'b00; in_data = 8'h3C;
    @(posedge clk); #1;
    check("b2b_lat_i_first", o_lat_i, 8'h3C);
    in_data = 8'hC3;
    d1 = -1; d2 = -1; acc2 = -1;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) begin
        rdy_prev = o_ready;
        @(posedge clk); #1;
        if (rdy_prev && in_valid) begin
          acc2 = k; in_valid = 1'b0;
        end
      end
      if (o_done) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
    end
    check("b2b_first_done", d1, 4);
    check("b2b_second_accept", acc2, 6);
    check("b2b_done_spacing", d2 - d1, 6);
    check("b2b_lat_i_second", o_lat_i, 8'hC3);

    // Reset while the gate is open
    in_valid = 1'b1; in_cmd = 2'b00; in_data = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_ge_open", o_ge, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ge_dropped", o_ge, 0);
    check("abort_lat_i", o_lat_i, 0);
    check("abort_ready", o_ready, 0);
    dcount = 0;
    repeat (2) begin
      @(posedge clk); #1; dcount += int'(o_done);
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1; dcount += int'(o_done);
    end
    check("abort_no_done", dcount, 0);
    run_cmd(mk(2'b00, 8'h01, 1'b0, 8'h01, 4, 2, 0, 0), "after_abort");

    // Long-timing instance
    sel = 1'b1;
    run_cmd(mk(2'b11, 8'h5A, 1'b0, 8'h00, 0, 0, 0, 0), "t15_nop");
    run_cmd(mk(2'b00, 8'h96, 1'b0, 8'h96, 45, 15, 0, 0), "t15_write");
    run_cmd(mk(2'b01, 8'h00, 1'b0, 8'h96, 15, 0, 15, 0), "t15_set");
    sel = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
